// File: rtl/eco32_core_ifu_evm_arb.sv
// Four-channel round-robin arbiter feeding the IFU event-injection port.
// Define ECO32_EVM_ARB_PRIO0_EN to give channel 0 fixed priority over channels 1..3.
module eco32_core_ifu_evm_arb #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rq_req,
  input  logic [15:0] rq_eid,
  input  logic [15:0] rq_erx,
  output logic [3:0]  rq_ack,
  input  logic [3:0]  ch_ena,
  output logic        o_req,
  output logic [3:0]  o_eid,
  output logic [3:0]  o_erx,
  output logic [1:0]  o_src,
  input  logic        o_ack,
  output logic        o_drop
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_GAP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_gnt;
  logic [3:0]  r_eid;
  logic [3:0]  r_erx;
  logic [7:0]  r_tcnt;
  logic        r_drop;
  logic [3:0]  w_elig;
  logic [1:0]  w_win;
  logic        w_found;
  logic        w_tmo;

  assign w_elig = rq_req & ch_ena;

  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && w_elig[r_ptr + 2'(i)]) begin
        w_win   = r_ptr + 2'(i);
        w_found = 1'b1;
      end
    end
`ifdef ECO32_EVM_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_win = 2'd0;
    end
`endif
  end

  // Counter holds the number of ISSUE cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT-1.
  always_comb begin
    w_tmo = 1'b0;
    if (TIMEOUT != 0) begin
      w_tmo = (r_tcnt == 8'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_elig) w_next = S_LOAD;
      S_LOAD:  w_next = S_ISSUE;
      S_ISSUE: if (o_ack || w_tmo) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_eid  <= '0;
      r_erx  <= '0;
      r_tcnt <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_gnt <= w_win;
            r_eid <= rq_eid[{w_win, 2'b00} +: 4];
            r_erx <= rq_erx[{w_win, 2'b00} +: 4];
          end
        end
        S_LOAD: begin
          r_tcnt <= '0;
        end
        S_ISSUE: begin
          r_tcnt <= r_tcnt + 8'd1;
          r_drop <= !o_ack && w_tmo;
        end
        S_GAP: begin
`ifdef ECO32_EVM_ARB_PRIO0_EN
          if (r_gnt != 2'd0) begin
            r_ptr <= r_gnt + 2'd1;
          end
`else
          r_ptr <= r_gnt + 2'd1;
`endif
        end
        default: begin
          r_drop <= 1'b0;
        end
      endcase
    end
  end

  assign rq_ack = (r_state == S_LOAD) ? (4'b0001 << r_gnt) : '0;
  assign o_req  = (r_state == S_ISSUE);
  assign o_eid  = r_eid;
  assign o_erx  = r_erx;
  assign o_src  = r_gnt;
  assign o_drop = r_drop;

endmodule

// File: tb/tb_eco32_core_ifu_evm_arb.sv
// Scoreboard bench for eco32_core_ifu_evm_arb: a timestamped transaction model
// predicts acks, issued events, issue lengths and drops; a monitor compares.
module tb_eco32_core_ifu_evm_arb;
  localparam int unsigned TO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rq_req;
  logic [15:0] rq_eid;
  logic [15:0] rq_erx;
  logic [3:0]  rq_ack;
  logic [3:0]  ch_ena;
  logic        o_req;
  logic [3:0]  o_eid;
  logic [3:0]  o_erx;
  logic [1:0]  o_src;
  logic        o_ack;
  logic        o_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eco32_core_ifu_evm_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rq_req(rq_req), .rq_eid(rq_eid), .rq_erx(rq_erx),
    .rq_ack(rq_ack), .ch_ena(ch_ena), .o_req(o_req), .o_eid(o_eid),
    .o_erx(o_erx), .o_src(o_src), .o_ack(o_ack), .o_drop(o_drop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [3:0] v; } ack_t;
  typedef struct { int src; logic [3:0] eid; logic [3:0] erx; } txn_t;
  ack_t q_ack[$];
  txn_t q_txn[$];
  int   q_len[$];
  int   q_drop[$];

  int m_ptr = 0, m_busy = 0, m_t0 = 0, m_n = 0, m_w = 0, m_idle_at = 0;

  function automatic int pick(input logic [3:0] e, input int p);
`ifdef ECO32_EVM_ARB_PRIO0_EN
    if (e[0]) return 0;
`endif
    for (int i = 0; i < 4; i++) if (e[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 0; m_busy = 0; m_idle_at = 0;
      q_ack.delete(); q_txn.delete(); q_len.delete(); q_drop.delete();
    end else if (!m_busy) begin
      if (cyc >= m_idle_at && (rq_req & ch_ena) != 4'd0) begin
        m_w = pick(rq_req & ch_ena, m_ptr);
        q_ack.push_back('{cyc: cyc + 1, v: 4'(1 << m_w)});
        q_txn.push_back('{src: m_w, eid: rq_eid[4*m_w +: 4], erx: rq_erx[4*m_w +: 4]});
        m_busy = 1; m_t0 = cyc; m_n = 0;
      end
    end else if (cyc >= m_t0 + 2) begin
      m_n++;
      if (o_ack || (TO != 0 && m_n == TO)) begin
        q_len.push_back(m_n);
        if (!o_ack) q_drop.push_back(cyc + 1);
        m_busy = 0;
        m_idle_at = cyc + 2;
`ifdef ECO32_EVM_ARB_PRIO0_EN
        if (m_w != 0) m_ptr = (m_w + 1) % 4;
`else
        m_ptr = (m_w + 1) % 4;
`endif
      end
    end
  end

  // ---------------- monitor ----------------
  int   glog[$];
  int   mon_drops = 0, mon_reqcyc = 0, ack3_cnt = 0, ack0_cnt = 0;
  logic prev_req = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    ack_t a; txn_t t; int l; int d;
    if (rst) begin
      prev_req = 1'b0; run_len = 0;
    end else begin
      if (rq_ack != 4'd0) begin
        if (rq_ack[3]) ack3_cnt++;
        if (rq_ack[0]) ack0_cnt++;
        if (q_ack.size() == 0) chk("unexpected_ack", rq_ack, 0);
        else begin
          a = q_ack.pop_front();
          chk("ack_value", rq_ack, a.v);
          chk("ack_cycle", cyc, a.cyc);
        end
      end
      if (o_req && !prev_req) begin
        glog.push_back(int'(o_src));
        run_len = 0;
        if (q_txn.size() == 0) chk("unexpected_issue", o_req, 0);
        else begin
          t = q_txn.pop_front();
          chk("issue_src", o_src, t.src);
          chk("issue_eid", o_eid, t.eid);
          chk("issue_erx", o_erx, t.erx);
        end
      end
      if (o_req) begin run_len++; mon_reqcyc++; end
      if (!o_req && prev_req) begin
        if (q_len.size() == 0) chk("unexpected_issue_end", run_len, 0);
        else begin l = q_len.pop_front(); chk("issue_length", run_len, l); end
      end
      if (o_drop) begin
        mon_drops++;
        chk("drop_while_req", o_req, 0);
        if (q_drop.size() == 0) chk("unexpected_drop", o_drop, 0);
        else begin d = q_drop.pop_front(); chk("drop_cycle", cyc, d); end
      end
      prev_req = o_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n, input int p_req, input int p_ack, input logic [3:0] rmask,
                     input bit chg_ena);
    logic [3:0] seen;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      seen = rq_ack;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (rq_req[k] && seen[k]) rq_req[k] = 1'b0;
        else if (!rq_req[k] && rmask[k] && $urandom_range(99) < p_req) begin
          rq_req[k] = 1'b1;
          rq_eid[4*k +: 4] = 4'($urandom);
          rq_erx[4*k +: 4] = 4'($urandom);
        end
      end
      o_ack = ($urandom_range(99) < p_ack);
      if (chg_ena && $urandom_range(19) == 0) ch_ena = 4'($urandom);
    end
  endtask

  task automatic drain();
    ch_ena = 4'hF;
    run(20, 0, 100, 4'h0, 1'b0);
  endtask

  initial begin
    int g0, d0, r0, a3, a0, bound;
    rst = 1'b1; rq_req = '0; rq_eid = '0; rq_erx = '0; ch_ena = 4'hF; o_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_o_req", o_req, 0);
    chk("reset_o_eid", o_eid, 0);
    chk("reset_o_erx", o_erx, 0);
    chk("reset_o_src", o_src, 0);
    chk("reset_rq_ack", rq_ack, 0);
    chk("reset_o_drop", o_drop, 0);

    // single event, o_ack tied high
    @(posedge clk); #1;
    rst = 1'b0; rq_req = 4'b0001; rq_eid[3:0] = 4'd5; rq_erx[3:0] = 4'd9; o_ack = 1'b1;
    @(negedge clk); chk("c0_rq_ack", rq_ack, 0);
    @(negedge clk); chk("c1_rq_ack", rq_ack, 4'b0001); chk("c1_o_req", o_req, 0);
    @(posedge clk); #1; rq_req = 4'b0000;
    @(negedge clk);
    chk("c2_o_req", o_req, 1); chk("c2_o_eid", o_eid, 5);
    chk("c2_o_erx", o_erx, 9); chk("c2_o_src", o_src, 0);
    @(negedge clk); chk("c3_o_req", o_req, 0);
    @(negedge clk); chk("c4_o_req", o_req, 0); chk("c4_rq_ack", rq_ack, 0);
    chk("hold_o_eid", o_eid, 5);
    drain();

    // all four continuously requesting
    g0 = glog.size();
    run(48, 100, 100, 4'hF, 1'b0);
    chk("rr_grant_count_ok", (glog.size() - g0) >= 8, 1);
    for (int i = g0; i + 1 < glog.size(); i++) begin
`ifdef ECO32_EVM_ARB_PRIO0_EN
      chk("prio_all_grant", glog[i + 1], 0);
`else
      chk("rr_all_order", glog[i + 1], (glog[i] + 1) % 4);
`endif
    end
    drain();

    // ptr = 3 via a grant of channel 2, then channel 3 masked
    rq_req = 4'b0100;
    run(10, 0, 100, 4'h0, 1'b0);
    a3 = ack3_cnt; a0 = ack0_cnt;
    rq_req = 4'b1001; ch_ena = 4'b0001;
    run(16, 0, 100, 4'h0, 1'b0);
    chk("masked_ch3_acks", ack3_cnt - a3, 0);
    chk("masked_ch0_acks", ack0_cnt - a0, 1);
    drain();
    chk("unmasked_ch3_acks", ack3_cnt - a3, 1);

    // timeout: two channels, o_ack held low
    d0 = mon_drops; r0 = mon_reqcyc;
    rq_req = 4'b0110;
    run(24, 0, 0, 4'h0, 1'b0);
    chk("timeout_drops", mon_drops - d0, 2);
    chk("timeout_req_cycles", mon_reqcyc - r0, 2 * TO);
    drain();

    // reset during ISSUE; ptr is 2 after serving channel 1
    rq_req = 4'b0010;
    run(10, 0, 100, 4'h0, 1'b0);
    @(posedge clk); #1;
    rq_req = 4'b1010; o_ack = 1'b0;
    bound = 0;
    while (!o_req && bound < 20) begin @(negedge clk); bound++; end
    chk("rst_test_reached_issue", o_req, 1);
    chk("rst_test_src_before", o_src, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_async_o_req", o_req, 0);
    chk("rst_async_rq_ack", rq_ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    g0 = glog.size();
    run(20, 0, 100, 4'h0, 1'b0);
    chk("rst_regrant_count", glog.size() - g0, 2);
    if (glog.size() - g0 >= 2) begin
      chk("rst_regrant_first", glog[g0], 1);
      chk("rst_regrant_second", glog[g0 + 1], 3);
    end
    drain();

    // channels 0 and 2 continuous
    g0 = glog.size();
    run(40, 100, 100, 4'b0101, 1'b0);
    chk("ch02_grant_count_ok", (glog.size() - g0) >= 6, 1);
    for (int i = g0; i + 1 < glog.size(); i++) begin
`ifdef ECO32_EVM_ARB_PRIO0_EN
      chk("prio0_wins", glog[i + 1], 0);
`else
      chk("ch02_alternate", glog[i + 1], (glog[i] == 0) ? 2 : 0);
`endif
    end
    drain();

    // randomized traffic with moving enables and sparse o_ack
    run(1500, 25, 40, 4'hF, 1'b1);
    drain();
    run(20, 0, 100, 4'h0, 1'b0);

    chk("sb_ack_empty", q_ack.size(), 0);
    chk("sb_txn_empty", q_txn.size(), 0);
    chk("sb_len_empty", q_len.size(), 0);
    chk("sb_drop_empty", q_drop.size(), 0);
    chk("model_idle", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
